// File: rtl/cache_pkg.sv
// Shared sizing, FSM state encoding and address field helpers for the MEM-stage data cache.
//   INDEX_BITS : log2 of the line count (one word per line)
//   TAG_BITS   : word-address bits above the index
//   getIndex / getTag : split a byte address into line index and tag
package cache_pkg;

  localparam int unsigned INDEX_BITS = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned TAG_BITS   = 30 - INDEX_BITS;
  localparam int unsigned NUM_LINES  = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } cacheState_e;

  // Line index sits just above the byte offset.
  function automatic logic [INDEX_BITS-1:0] getIndex(input logic [ADDR_WIDTH-1:0] addr);
    return INDEX_BITS'(addr >> 2);
  endfunction

  // Tag is everything above the index.
  function automatic logic [TAG_BITS-1:0] getTag(input logic [ADDR_WIDTH-1:0] addr);
    return TAG_BITS'(addr >> (INDEX_BITS + 2));
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Asynchronous read and synchronous write share one index; a write always
// sets the line valid. rst clears every valid bit (tags/data keep contents).
//   clk, rst              : clock, synchronous active-high reset
//   index                 : line selected for read and write
//   lineValid/Tag/Data    : asynchronous read of the selected line
//   writeEn/Tag/Data      : write {valid=1, tag, data} at the clock edge
module cache_line_array
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  lineValid,
  output logic [TAG_BITS-1:0]   lineTag,
  output logic [DATA_WIDTH-1:0] lineData,
  input  logic                  writeEn,
  input  logic [TAG_BITS-1:0]   writeTag,
  input  logic [DATA_WIDTH-1:0] writeData
);

  logic [NUM_LINES-1:0]  validBits;
  logic [TAG_BITS-1:0]   tagMem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] dataMem [NUM_LINES];

  // Valid bits are the only reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      validBits <= '0;
    end else if (writeEn) begin
      validBits[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      tagMem[index]  <= writeTag;
      dataMem[index] <= writeData;
    end
  end

  assign lineValid = validBits[index];
  assign lineTag   = tagMem[index];
  assign lineData  = dataMem[index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Hits on loads return data in the same cycle; misses and all stores stall
// the pipeline while the request/ready handshake with main memory completes.
// Sizing comes from cache_pkg.
//   clk, rst                  : clock, synchronous active-high reset
//   memRead, memWrite         : CPU load/store request (held while stall=1)
//   address, writeData        : CPU byte address and store data
//   hit, readData, stall      : lookup result, load data, pipeline freeze
//   memReqRead, memReqWrite   : main-memory requests
//   memAddr, memWData         : word-aligned address and store data to memory
//   memRData, memReady        : memory read data and one-cycle completion pulse
module data_cache_controller
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  stall,
  output logic                  memReqRead,
  output logic                  memReqWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  input  logic                  memReady
);

  cacheState_e state, nextState;

  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic                  lineValid;
  logic [TAG_BITS-1:0]   lineTag;
  logic [DATA_WIDTH-1:0] lineData;
  logic                  lookupHit;
  logic                  lineWrite;
  logic                  lineWriteEn;
  logic [DATA_WIDTH-1:0] lineWData;
  logic                  unusedByteOffset;

  assign reqIndex  = getIndex(address);
  assign reqTag    = getTag(address);
  assign lookupHit = lineValid && (lineTag == reqTag);

  // A fill landing in the same cycle as reset is abandoned.
  assign lineWriteEn = lineWrite && !rst;

  cache_line_array lineArray (
    .clk       (clk),
    .rst       (rst),
    .index     (reqIndex),
    .lineValid (lineValid),
    .lineTag   (lineTag),
    .lineData  (lineData),
    .writeEn   (lineWriteEn),
    .writeTag  (reqTag),
    .writeData (lineWData)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake/stall decode.
  always_comb begin
    nextState   = state;
    hit         = 1'b0;
    stall       = 1'b0;
    memReqRead  = 1'b0;
    memReqWrite = 1'b0;
    lineWrite   = 1'b0;
    lineWData   = writeData;

    unique case (state)
      IDLE: begin
        // Simultaneous read+write is illegal and resolved as a write.
        if (memWrite) begin
          stall     = 1'b1;
          hit       = lookupHit;
          lineWrite = lookupHit;
          nextState = WR_WAIT;
        end else if (memRead) begin
          if (lookupHit) begin
            hit = 1'b1;
          end else begin
            stall     = 1'b1;
            nextState = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        memReqRead = 1'b1;
        stall      = 1'b1;
        lineWData  = memRData;
        if (memReady) begin
          lineWrite = 1'b1;
          nextState = IDLE;
        end
      end
      WR_WAIT: begin
        memReqWrite = 1'b1;
        // Release on the ready cycle so the pipeline advances on that edge.
        stall       = !memReady;
        if (memReady) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign readData         = lineData;
  assign memAddr          = {address[ADDR_WIDTH-1:2], 2'b00};
  assign memWData         = writeData;
  assign unusedByteOffset = ^address[1:0];

endmodule

// File: tb/tb_data_cache_controller.sv
module tb_data_cache_controller;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        hit;
  logic [31:0] readData;
  logic        stall;
  logic        memReqRead;
  logic        memReqWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;

  int checks = 0;
  int errors = 0;

  data_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .address     (address),
    .writeData   (writeData),
    .hit         (hit),
    .readData    (readData),
    .stall       (stall),
    .memReqRead  (memReqRead),
    .memReqWrite (memReqWrite),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memRData    (memRData),
    .memReady    (memReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        eHit;
    logic        eStall;
    logic        eReqRd;
    logic        eReqWr;
    logic        chkRd;
    logic [31:0] eRd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ready, input logic [31:0] rdata,
                              input logic eHit, input logic eStall, input logic eReqRd,
                              input logic eReqWr, input logic chkRd, input logic [31:0] eRd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ready = ready; v.rdata = rdata;
    v.eHit = eHit; v.eStall = eStall; v.eReqRd = eReqRd; v.eReqWr = eReqWr;
    v.chkRd = chkRd; v.eRd = eRd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic driveIdle();
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = 32'h0;
    writeData = 32'h0;
    memReady  = 1'b0;
    memRData  = 32'h0;
  endtask

  // Load with a responsive memory that raises memReady on the lat-th request cycle.
  task automatic readTxn(input string nm, input logic [31:0] addr, input int lat,
                         input logic [31:0] data, input int expStalls);
    int  stalls  = 0;
    int  waitCnt = 0;
    bit  done    = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk);
      #1;
      memRead  = 1'b1;
      memWrite = 1'b0;
      address  = addr;
      memReady = 1'b0;
      memRData = data;
      #1;
      if (memReqRead) begin
        waitCnt++;
        if (waitCnt == lat) memReady = 1'b1;
        chk({nm, " memAddr"}, memAddr, {addr[31:2], 2'b00});
      end
      #2;
      if (stall) begin
        stalls++;
      end else begin
        done = 1;
        chk({nm, " hit"}, 32'(hit), 32'd1);
        chk({nm, " readData"}, readData, data);
        chk({nm, " stallCycles"}, 32'(stalls), 32'(expStalls));
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: stall still %0d after 20 cycles, required 0", nm, stall);
    end
  endtask

  initial begin
    rst = 1'b1;
    driveIdle();

    // rd wr addr wdata rdy rdata | hit stall reqRd reqWr chkRd eRd
    // Test 1: cold read of 0x40, memory ready on the 3rd request cycle.
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 1, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'hDEADBEEF));
    // Test 2: repeat read hits with no memory request.
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'hDEADBEEF));
    // Test 3: store to resident 0x40.
    vecs.push_back(mk(0, 1, 32'h40, 32'h12345678, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 32'h12345678, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40, 32'h12345678, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'h12345678));
    // Test 4: store miss to 0x80 (0-wait memory), no allocate.
    vecs.push_back(mk(0, 1, 32'h80, 32'hCAFEF00D, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h80, 32'hCAFEF00D, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h80, 0, 0, 0,            0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h80, 0, 1, 32'hCAFEF00D, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h80, 0, 0, 0,            1, 0, 0, 0, 1, 32'hCAFEF00D));
    // Test 5: 0x440 aliases index 0, then 0x40 misses again.
    vecs.push_back(mk(1, 0, 32'h440, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h440, 0, 0, 0,           0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h440, 0, 1, 32'h0BADF00D, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h440, 0, 0, 0,           1, 0, 0, 0, 1, 32'h0BADF00D));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 1, 32'h12345678, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'h12345678));
    // Idle cycle with a stray memReady, then a hit is undisturbed.
    vecs.push_back(mk(0, 0, 32'h40, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'h12345678));
    // Read+write together behaves as a write.
    vecs.push_back(mk(1, 1, 32'h40, 32'h55AA55AA, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h40, 32'h55AA55AA, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0,            1, 0, 0, 0, 1, 32'h55AA55AA));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("reset hit", 32'(hit), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset memReqRead", 32'(memReqRead), 32'd0);
    chk("reset memReqWrite", 32'(memReqWrite), 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      memRead   = vecs[i].rd;
      memWrite  = vecs[i].wr;
      address   = vecs[i].addr;
      writeData = vecs[i].wdata;
      memReady  = vecs[i].ready;
      memRData  = vecs[i].rdata;
      #3;
      chk($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].eHit));
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].eStall));
      chk($sformatf("vec%0d memReqRead", i), 32'(memReqRead), 32'(vecs[i].eReqRd));
      chk($sformatf("vec%0d memReqWrite", i), 32'(memReqWrite), 32'(vecs[i].eReqWr));
      if (vecs[i].chkRd)
        chk($sformatf("vec%0d readData", i), readData, vecs[i].eRd);
      if (vecs[i].eReqRd || vecs[i].eReqWr)
        chk($sformatf("vec%0d memAddr", i), memAddr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].eReqWr)
        chk($sformatf("vec%0d memWData", i), memWData, vecs[i].wdata);
    end

    // Test 6: reset while in RD_WAIT, with memReady coinciding with reset.
    @(posedge clk);
    #1;
    driveIdle();
    memRead = 1'b1;
    address = 32'h44;
    #3;
    chk("rstRd miss stall", 32'(stall), 32'd1);
    @(posedge clk);
    #4;
    chk("rstRd memReqRead", 32'(memReqRead), 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    memReady = 1'b1;
    memRData = 32'hFFFF0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveIdle();
    #3;
    chk("rstRd after memReqRead", 32'(memReqRead), 32'd0);
    chk("rstRd after stall", 32'(stall), 32'd0);
    chk("rstRd after hit", 32'(hit), 32'd0);

    // Abandoned fill left nothing; earlier fills were invalidated.
    readTxn("rd44 postReset", 32'h44, 2, 32'h44444444, 3);
    readTxn("rd40 postReset", 32'h40, 1, 32'h55AA55AA, 2);
    readTxn("rd40 rehit", 32'h40, 1, 32'h55AA55AA, 0);
    readTxn("rd44 rehit", 32'h44, 1, 32'h44444444, 0);

    @(posedge clk);
    #1;
    driveIdle();
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
